// File: rtl/hazard_ctrl_unit.sv
// Hazard control beside the 5-stage datapath: EX operand forwarding select,
// load-use stall sequencing, branch flush and saturating hazard-event counters.
module hazard_ctrl_unit #(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic [REG_ADDR_W-1:0] RD_M,
  input  logic [REG_ADDR_W-1:0] RD_W,
  input  logic [REG_ADDR_W-1:0] RD_E,
  input  logic                  MemReadE,
  input  logic                  PCSrcE,
  input  logic [REG_ADDR_W-1:0] Rs1_E,
  input  logic [REG_ADDR_W-1:0] Rs2_E,
  input  logic [REG_ADDR_W-1:0] Rs1_D,
  input  logic [REG_ADDR_W-1:0] Rs2_D,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [CNT_W-1:0]      stall_events,
  output logic [CNT_W-1:0]      flush_events
);

  // state | meaning
  // RUN   | normal issue; load-use and branch flush are evaluated
  // STALL | holding F/D for the remaining load bubbles (r_cnt left)
  localparam logic [0:0]       S_RUN        = 1'b0;
  localparam logic [0:0]       S_STALL      = 1'b1;
  localparam logic [3:0]       STALL_RELOAD = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  logic [0:0]       r_state;
  logic [3:0]       r_cnt;
  logic [CNT_W-1:0] r_stall_events;
  logic [CNT_W-1:0] r_flush_events;

  logic [0:0] w_next_state;
  logic [3:0] w_next_cnt;
  logic       w_stall;
  logic       w_flush;
  logic       w_lu;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  // MEM result is younger than WB, so it wins when both match
  always_comb begin
    w_fwd_a = 2'b00;
    if (RegWriteM && (RD_M != '0) && (RD_M == Rs1_E))
      w_fwd_a = 2'b10;
    else if (RegWriteW && (RD_W != '0) && (RD_W == Rs1_E))
      w_fwd_a = 2'b01;

    w_fwd_b = 2'b00;
    if (RegWriteM && (RD_M != '0) && (RD_M == Rs2_E))
      w_fwd_b = 2'b10;
    else if (RegWriteW && (RD_W != '0) && (RD_W == Rs2_E))
      w_fwd_b = 2'b01;
  end

  assign w_lu = MemReadE && (RD_E != '0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_stall      = 1'b0;
    w_flush      = 1'b0;
    if (rst) begin
      w_next_state = S_RUN;
      w_next_cnt   = '0;
    end else if (PCSrcE) begin
      w_flush      = 1'b1;
      w_next_state = S_RUN;
      w_next_cnt   = '0;
    end else if (r_state == S_STALL) begin
      w_stall = 1'b1;
      if (r_cnt == 4'd1) begin
        w_next_state = S_RUN;
        w_next_cnt   = '0;
      end else begin
        w_next_cnt = r_cnt - 4'd1;
      end
    end else if (w_lu) begin
      w_stall = 1'b1;
      if (LOAD_STALL_CYCLES > 1) begin
        w_next_state = S_STALL;
        w_next_cnt   = STALL_RELOAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_RUN;
      r_cnt          <= '0;
      r_stall_events <= '0;
      r_flush_events <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_stall && (r_stall_events != CNT_MAX))
        r_stall_events <= r_stall_events + CNT_W'(1);
      if (w_flush && (r_flush_events != CNT_MAX))
        r_flush_events <= r_flush_events + CNT_W'(1);
    end
  end

  assign ForwardAE    = rst ? 2'b00 : w_fwd_a;
  assign ForwardBE    = rst ? 2'b00 : w_fwd_b;
  assign StallF       = w_stall;
  assign StallD       = w_stall;
  assign FlushD       = w_flush;
  assign FlushE       = w_stall | w_flush;
  assign stall_events = r_stall_events;
  assign flush_events = r_flush_events;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: three instances (bubble lengths 1, 3 and 4; the
// last with 4-bit counters) share stimulus and are checked against a model.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       RegWriteM, RegWriteW, MemReadE, PCSrcE;
  logic [4:0] RD_M, RD_W, RD_E, Rs1_E, Rs2_E, Rs1_D, Rs2_D;

  logic [2:0][1:0] fa, fb;
  logic [2:0]      sf, sd, fd, fe;
  logic [15:0]     se0, se1, fl0, fl1;
  logic [3:0]      se2, fl2;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: bubbles still owed and event counts, per instance
  int rem  [3];
  int scnt [3];
  int fcnt [3];

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .RD_M(RD_M), .RD_W(RD_W), .RD_E(RD_E), .MemReadE(MemReadE), .PCSrcE(PCSrcE),
    .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D),
    .ForwardAE(fa[0]), .ForwardBE(fb[0]), .StallF(sf[0]), .StallD(sd[0]),
    .FlushD(fd[0]), .FlushE(fe[0]), .stall_events(se0), .flush_events(fl0));

  hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .RD_M(RD_M), .RD_W(RD_W), .RD_E(RD_E), .MemReadE(MemReadE), .PCSrcE(PCSrcE),
    .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D),
    .ForwardAE(fa[1]), .ForwardBE(fb[1]), .StallF(sf[1]), .StallD(sd[1]),
    .FlushD(fd[1]), .FlushE(fe[1]), .stall_events(se1), .flush_events(fl1));

  hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(4), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .RD_M(RD_M), .RD_W(RD_W), .RD_E(RD_E), .MemReadE(MemReadE), .PCSrcE(PCSrcE),
    .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D),
    .ForwardAE(fa[2]), .ForwardBE(fb[2]), .StallF(sf[2]), .StallD(sd[2]),
    .FlushD(fd[2]), .FlushE(fe[2]), .stall_events(se2), .flush_events(fl2));

  function automatic int lsc(int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  function automatic int cmax(int k);
    return (k == 2) ? 15 : 65535;
  endfunction

  // observed DUT values, gathered per instance
  function automatic logic [3:0] obs_ctrl(int k);
    return {sf[k], sd[k], fd[k], fe[k]};
  endfunction

  function automatic logic [15:0] obs_se(int k);
    return (k == 0) ? se0 : ((k == 1) ? se1 : {12'b0, se2});
  endfunction

  function automatic logic [15:0] obs_fl(int k);
    return (k == 0) ? fl0 : ((k == 1) ? fl1 : {12'b0, fl2});
  endfunction

  // reference model
  function automatic logic model_lu();
    return MemReadE && (RD_E != 0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));
  endfunction

  function automatic logic model_stall(int k);
    return !rst && !PCSrcE && ((rem[k] > 0) || model_lu());
  endfunction

  function automatic logic model_flush();
    return !rst && PCSrcE;
  endfunction

  function automatic logic [3:0] exp_ctrl(int k);
    logic s, f;
    s = model_stall(k);
    f = model_flush();
    return {s, s, f, s | f};
  endfunction

  function automatic logic [1:0] exp_fwd(logic [4:0] rs);
    if (rst) return 2'b00;
    if (RegWriteM && RD_M != 0 && RD_M == rs) return 2'b10;
    if (RegWriteW && RD_W != 0 && RD_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  // advance model by one cycle using the inputs currently applied, then clock
  task automatic tick();
    logic s, f;
    for (int k = 0; k < 3; k++) begin
      s = model_stall(k);
      f = model_flush();
      if (rst) begin
        rem[k] = 0; scnt[k] = 0; fcnt[k] = 0;
      end else begin
        if (f) rem[k] = 0;
        else if (rem[k] > 0) rem[k] = rem[k] - 1;
        else if (model_lu()) rem[k] = lsc(k) - 1;
        if (s && scnt[k] < cmax(k)) scnt[k] = scnt[k] + 1;
        if (f && fcnt[k] < cmax(k)) fcnt[k] = fcnt[k] + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    RegWriteM = 0; RegWriteW = 0; MemReadE = 0; PCSrcE = 0;
    RD_M = 0; RD_W = 0; RD_E = 0; Rs1_E = 0; Rs2_E = 0; Rs1_D = 0; Rs2_D = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    RegWriteM = 1; RegWriteW = 1; MemReadE = 1; PCSrcE = 1;
    RD_M = 5'd3; RD_W = 5'd3; RD_E = 5'd3;
    Rs1_E = 5'd3; Rs2_E = 5'd3; Rs1_D = 5'd3; Rs2_D = 5'd3;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (obs_ctrl(k) !== 4'b0000 || fa[k] !== 2'b00 || fb[k] !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_outputs inst%0d: ctrl=%b fa=%b fb=%b expected all zero",
                 k, obs_ctrl(k), fa[k], fb[k]);
      end
    end
    tick();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (obs_se(k) !== 16'd0 || obs_fl(k) !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_counters inst%0d: stall=%0d flush=%0d expected 0/0",
                 k, obs_se(k), obs_fl(k));
      end
    end
    tick();
    rst = 0;
    clear_inputs();
    tick();
  endtask

  task automatic test_forwarding();
    logic [1:0] ea, eb;
    do_reset();
    RegWriteM = 1; RegWriteW = 1; RD_M = 5'd5; RD_W = 5'd5; Rs1_E = 5'd5;
    #1;
    n_tests++;
    if (fa[0] !== 2'b10) begin
      n_fail++; $display("FAIL fwd_mem_priority: got %b expected 10", fa[0]);
    end
    RD_M = 5'd0;
    #1;
    n_tests++;
    if (fa[0] !== 2'b01) begin
      n_fail++; $display("FAIL fwd_wb: got %b expected 01", fa[0]);
    end
    Rs1_E = 5'd0; RD_W = 5'd0;
    #1;
    n_tests++;
    if (fa[0] !== 2'b00) begin
      n_fail++; $display("FAIL fwd_x0: got %b expected 00", fa[0]);
    end
    for (int i = 0; i < 60; i++) begin
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      RD_M  = 5'($urandom_range(0, 3));
      RD_W  = 5'($urandom_range(0, 3));
      Rs1_E = 5'($urandom_range(0, 3));
      Rs2_E = 5'($urandom_range(0, 3));
      #1;
      ea = exp_fwd(Rs1_E);
      eb = exp_fwd(Rs2_E);
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (fa[k] !== ea || fb[k] !== eb) begin
          n_fail++;
          $display("FAIL fwd_random inst%0d: got A=%b B=%b expected A=%b B=%b",
                   k, fa[k], fb[k], ea, eb);
        end
      end
    end
    clear_inputs();
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_use();
    int hs [3];
    do_reset();
    for (int k = 0; k < 3; k++) hs[k] = 0;
    MemReadE = 1; RD_E = 5'd7; Rs2_D = 5'd7; Rs1_D = 5'd3;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (obs_ctrl(k) !== exp_ctrl(k)) begin
          n_fail++;
          $display("FAIL load_use_ctrl inst%0d cyc%0d: got %b expected %b",
                   k, c, obs_ctrl(k), exp_ctrl(k));
        end
        if (sf[k] === 1'b1) hs[k]++;
      end
      tick();
      if (c == 0) clear_inputs();
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (hs[k] != lsc(k) || obs_se(k) !== 16'(lsc(k))) begin
        n_fail++;
        $display("FAIL load_use_len inst%0d: stalled %0d cycles, stall_events=%0d, expected %0d",
                 k, hs[k], obs_se(k), lsc(k));
      end
    end
    tick();
  endtask

  task automatic test_branch_priority();
    do_reset();
    PCSrcE = 1; MemReadE = 1; RD_E = 5'd4; Rs1_D = 5'd4;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (obs_ctrl(k) !== 4'b0011) begin
        n_fail++;
        $display("FAIL branch_ctrl inst%0d: got %b expected 0011", k, obs_ctrl(k));
      end
    end
    tick();
    clear_inputs();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (obs_fl(k) !== 16'd1 || obs_se(k) !== 16'd0 || obs_ctrl(k) !== 4'b0000) begin
        n_fail++;
        $display("FAIL branch_counts inst%0d: flush=%0d stall=%0d ctrl=%b expected 1/0/0000",
                 k, obs_fl(k), obs_se(k), obs_ctrl(k));
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    MemReadE = 1; RD_E = 5'd9; Rs1_D = 5'd9;
    @(negedge clk);
    n_tests++;
    if (obs_ctrl(2) !== 4'b1101) begin
      n_fail++; $display("FAIL midrst_first inst2: got %b expected 1101", obs_ctrl(2));
    end
    tick();
    clear_inputs();
    rst = 1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (obs_ctrl(k) !== 4'b0000) begin
        n_fail++;
        $display("FAIL midrst_during inst%0d: got %b expected 0000", k, obs_ctrl(k));
      end
    end
    tick();
    rst = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (obs_ctrl(k) !== 4'b0000 || obs_se(k) !== 16'd0 || obs_fl(k) !== 16'd0) begin
          n_fail++;
          $display("FAIL midrst_after inst%0d cyc%0d: ctrl=%b stall=%0d flush=%0d expected 0000/0/0",
                   k, c, obs_ctrl(k), obs_se(k), obs_fl(k));
        end
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    MemReadE = 1; RD_E = 5'd7; Rs1_D = 5'd7;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (obs_ctrl(k) !== exp_ctrl(k) || obs_se(k) !== 16'(scnt[k])) begin
          n_fail++;
          $display("FAIL saturation inst%0d cyc%0d: ctrl=%b stall=%0d expected %b/%0d",
                   k, c, obs_ctrl(k), obs_se(k), exp_ctrl(k), scnt[k]);
        end
      end
      tick();
    end
    @(negedge clk);
    n_tests++;
    if (se2 !== 4'd15 || se0 !== 16'd24) begin
      n_fail++;
      $display("FAIL saturation_final: inst2=%0d inst0=%0d expected 15/24", se2, se0);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 99) < 2);
      PCSrcE    = ($urandom_range(0, 99) < 12);
      MemReadE  = ($urandom_range(0, 99) < 35);
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      RD_M  = 5'($urandom_range(0, 3));
      RD_W  = 5'($urandom_range(0, 3));
      RD_E  = 5'($urandom_range(0, 3));
      Rs1_E = 5'($urandom_range(0, 3));
      Rs2_E = 5'($urandom_range(0, 3));
      Rs1_D = 5'($urandom_range(0, 3));
      Rs2_D = 5'($urandom_range(0, 3));
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (obs_ctrl(k) !== exp_ctrl(k) || fa[k] !== exp_fwd(Rs1_E) ||
            fb[k] !== exp_fwd(Rs2_E) || obs_se(k) !== 16'(scnt[k]) ||
            obs_fl(k) !== 16'(fcnt[k])) begin
          n_fail++;
          $display("FAIL random inst%0d cyc%0d: ctrl=%b fa=%b fb=%b stall=%0d flush=%0d expected %b/%b/%b/%0d/%0d",
                   k, c, obs_ctrl(k), fa[k], fb[k], obs_se(k), obs_fl(k),
                   exp_ctrl(k), exp_fwd(Rs1_E), exp_fwd(Rs2_E), scnt[k], fcnt[k]);
        end
      end
      tick();
    end
    rst = 0;
    clear_inputs();
    tick();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rem[k] = 0; scnt[k] = 0; fcnt[k] = 0;
    end
    rst = 1;
    clear_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_priority();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
